// File: rtl/switch_debounce_pulse_if.sv
// -----------------------------------------------------------------------------
// switch_debounce_pulse_if
// Groups the switch input and the conditioned outputs of switch_debounce_pulse.
//   sw_in      : raw asynchronous switch/button level (driven by the board side)
//   sw_level   : debounced, registered level
//   rise_pulse : one-cycle pulse on each accepted 0->1 transition (and repeats)
//   fall_pulse : one-cycle pulse on each accepted 1->0 transition
//   busy       : high while a candidate transition is being qualified
// Modports:
//   master : the side that drives sw_in and consumes the conditioned outputs
//   slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface switch_debounce_pulse_if;
    logic sw_in;
    logic sw_level;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    modport master (
        output sw_in,
        input  sw_level,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    modport slave (
        input  sw_in,
        output sw_level,
        output rise_pulse,
        output fall_pulse,
        output busy
    );
endinterface

// File: rtl/switch_debounce_pulse.sv
// -----------------------------------------------------------------------------
// switch_debounce_pulse
// Front-end conditioning for a bouncing board switch. The raw level is brought
// into the clock domain with a two-flop synchroniser, qualified by a four-state
// FSM (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW) and turned into a clean level
// plus single-cycle rise/fall pulses. rise_pulse is meant to clock the first
// stage of the downstream ripple counter: one press, one count.
//
// Ports:
//   clk   : system clock, all flops on posedge
//   rst   : asynchronous reset, active low
//   sw_if : switch_debounce_pulse_if.slave (sw_in in; sw_level, rise_pulse,
//           fall_pulse, busy out - all outputs registered)
//
// Parameters:
//   STABLE_COUNT : cycles the synchronised input must hold a new value (>= 2)
//   REPEAT_COUNT : auto-repeat interval in cycles (>= 2), only meaningful with
//                  the optional feature below
//
// Optional feature (macro SWITCH_DEBOUNCE_AUTO_REPEAT_EN):
//   When defined, holding the switch high in IDLE_HIGH emits an extra
//   rise_pulse every REPEAT_COUNT cycles. When undefined, no repeat logic
//   exists and each accepted press yields exactly one rise_pulse.
// -----------------------------------------------------------------------------
module switch_debounce_pulse #(
    parameter int unsigned STABLE_COUNT = 1000000,
    parameter int unsigned REPEAT_COUNT = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    switch_debounce_pulse_if.slave  sw_if
);

    // One counter width serves both the qualification and repeat counters.
    localparam int unsigned MAX_CNT = (STABLE_COUNT > REPEAT_COUNT) ? STABLE_COUNT : REPEAT_COUNT;
    localparam int unsigned CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;

`ifdef SWITCH_DEBOUNCE_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);
    logic [CNT_W-1:0] rep_q;
`endif

    // Synchroniser, qualification FSM and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SWITCH_DEBOUNCE_AUTO_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            s1_q   <= sw_if.sw_in;
            s2_q   <= s1_q;
            // Pulses default low so that any assertion lasts exactly one cycle.
            rise_q <= 1'b0;
            fall_q <= 1'b0;

            case (state_q)
                IDLE_LOW: begin
                    if (s2_q) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE_LOW;
                    end
                end

                WAIT_HIGH: begin
                    if (!s2_q) begin
                        // Bounce: drop back without touching the level.
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
`ifdef SWITCH_DEBOUNCE_AUTO_REPEAT_EN
                        rep_q   <= '0;
`endif
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end

                IDLE_HIGH: begin
                    if (!s2_q) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
`ifdef SWITCH_DEBOUNCE_AUTO_REPEAT_EN
                        // Held button: re-fire rise_pulse every REPEAT_COUNT cycles.
                        if (rep_q == REPEAT_LAST) begin
                            rep_q  <= '0;
                            rise_q <= 1'b1;
                        end else begin
                            rep_q  <= rep_q + CNT_ONE;
                        end
`else
                        state_q <= IDLE_HIGH;
`endif
                    end
                end

                WAIT_LOW: begin
                    if (s2_q) begin
                        // Bounce: return to the high idle state, level unchanged.
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
`ifdef SWITCH_DEBOUNCE_AUTO_REPEAT_EN
                        rep_q   <= '0;
`endif
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign sw_if.sw_level   = level_q;
    assign sw_if.rise_pulse = rise_q;
    assign sw_if.fall_pulse = fall_q;
    assign sw_if.busy       = busy_q;

endmodule

// File: tb/tb_switch_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce_pulse
// Directed bench for switch_debounce_pulse with STABLE_COUNT=4, REPEAT_COUNT=8.
// A cycle table covers a clean press and release; hand-written sequences cover
// bounce rejection, reset during qualification, repeated presses feeding a
// counter model, and hold behaviour (auto-repeat when the macro is defined).
// -----------------------------------------------------------------------------
module tb_switch_debounce_pulse;

    logic clk;
    logic rst;

    switch_debounce_pulse_if dut_if ();

    switch_debounce_pulse #(
        .STABLE_COUNT (4),
        .REPEAT_COUNT (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw_if (dut_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sw;
        logic lvl;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t vecs [17];

    int n_checks;
    int n_errors;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        check("pulse_exclusive", int'(dut_if.rise_pulse & dut_if.fall_pulse), 0);
    endtask

    task automatic settle_low(input int n);
        dut_if.sw_in = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int rise_cnt;
        int fall_cnt;
        int fall_at;
        int rise_at;
        int busy_cnt;
        int lvl_cnt;
        int found;
        logic [3:0] model_cnt;
        logic [7:0] pat;

        n_checks = 0;
        n_errors = 0;
        clk = 1'b0;
        rst = 1'b0;
        dut_if.sw_in = 1'b0;

        // Clean press (rows 0-8) then release (rows 9-16): {sw, lvl, rise, fall, busy}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_level", int'(dut_if.sw_level), 0);
        check("reset_rise",  int'(dut_if.rise_pulse), 0);
        check("reset_fall",  int'(dut_if.fall_pulse), 0);
        check("reset_busy",  int'(dut_if.busy), 0);
        rst = 1'b1;
        settle_low(4);

        // Table: clean press and release
        for (int i = 0; i < 17; i++) begin
            dut_if.sw_in = vecs[i].sw;
            step();
            check($sformatf("tbl%0d_level", i), int'(dut_if.sw_level),   int'(vecs[i].lvl));
            check($sformatf("tbl%0d_rise", i),  int'(dut_if.rise_pulse), int'(vecs[i].rise));
            check($sformatf("tbl%0d_fall", i),  int'(dut_if.fall_pulse), int'(vecs[i].fall));
            check($sformatf("tbl%0d_busy", i),  int'(dut_if.busy),       int'(vecs[i].busy));
        end
        settle_low(6);

        // Bounce reject: 1,1,1,0,0,1,1,0 repeated five times, then held low
        pat = 8'b1110_0110;
        rise_cnt = 0; fall_cnt = 0; busy_cnt = 0; lvl_cnt = 0;
        for (int i = 0; i < 52; i++) begin
            dut_if.sw_in = (i < 40) ? pat[7 - (i % 8)] : 1'b0;
            step();
            rise_cnt += int'(dut_if.rise_pulse);
            fall_cnt += int'(dut_if.fall_pulse);
            busy_cnt += int'(dut_if.busy);
            lvl_cnt  += int'(dut_if.sw_level);
        end
        check("bounce_rise_count",  rise_cnt, 0);
        check("bounce_fall_count",  fall_cnt, 0);
        check("bounce_level_high",  lvl_cnt, 0);
        check("bounce_busy_seen",   int'(busy_cnt > 0), 1);
        check("bounce_busy_idle",   int'(dut_if.busy), 0);

        // Press for 20 cycles, then release
        rise_cnt = 0; fall_cnt = 0; fall_at = -1;
        dut_if.sw_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            rise_cnt += int'(dut_if.rise_pulse);
            fall_cnt += int'(dut_if.fall_pulse);
        end
        check("press_level_high", int'(dut_if.sw_level), 1);
        dut_if.sw_in = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            rise_cnt += int'(dut_if.rise_pulse);
            if (dut_if.fall_pulse) begin
                fall_cnt++;
                if (fall_at < 0) fall_at = k;
            end
        end
`ifdef SWITCH_DEBOUNCE_AUTO_REPEAT_EN
        check("press_rise_count", rise_cnt, 2);
`else
        check("press_rise_count", rise_cnt, 1);
`endif
        check("press_fall_count", fall_cnt, 1);
        check("press_fall_delay", fall_at, 6);
        check("press_level_low",  int'(dut_if.sw_level), 0);

        // Reset while qualifying a press (counter at 2)
        dut_if.sw_in = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("midq_busy_before", int'(dut_if.busy), 1);
        rst = 1'b0;
        #1;
        check("midq_rst_level", int'(dut_if.sw_level), 0);
        check("midq_rst_rise",  int'(dut_if.rise_pulse), 0);
        check("midq_rst_fall",  int'(dut_if.fall_pulse), 0);
        check("midq_rst_busy",  int'(dut_if.busy), 0);
        repeat (2) @(posedge clk);
        #2;
        check("midq_held_busy", int'(dut_if.busy), 0);
        rst = 1'b1;
        rise_cnt = 0; rise_at = -1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (dut_if.rise_pulse) begin
                rise_cnt++;
                if (rise_at < 0) rise_at = k;
            end
        end
        check("midq_rise_count", rise_cnt, 1);
        check("midq_rise_delay", rise_at, 6);
        check("midq_level",      int'(dut_if.sw_level), 1);
        settle_low(14);

        // Five presses stepping a down-counter driven by rise_pulse
        model_cnt = 4'd0;
        rise_cnt = 0; fall_cnt = 0;
        for (int p = 0; p < 5; p++) begin
            dut_if.sw_in = 1'b1;
            for (int i = 0; i < 10; i++) begin
                step();
                if (dut_if.rise_pulse) begin
                    rise_cnt++;
                    model_cnt = model_cnt - 4'd1;
                end
            end
            dut_if.sw_in = 1'b0;
            for (int i = 0; i < 12; i++) begin
                step();
                fall_cnt += int'(dut_if.fall_pulse);
            end
        end
        check("chain_rise_count", rise_cnt, 5);
        check("chain_fall_count", fall_cnt, 5);
        check("chain_counter",    int'(model_cnt), 11);

        // Long hold: one pulse at acceptance, plus repeats when enabled
        dut_if.sw_in = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (dut_if.rise_pulse) found = 1;
        end
        check("hold_accept_seen", found, 1);
        rise_cnt = found;
        for (int i = 0; i < 39; i++) begin
            step();
            rise_cnt += int'(dut_if.rise_pulse);
            fall_cnt += 0;
        end
        check("hold_level", int'(dut_if.sw_level), 1);
`ifdef SWITCH_DEBOUNCE_AUTO_REPEAT_EN
        check("hold_rise_count", rise_cnt, 5);
`else
        check("hold_rise_count", rise_cnt, 1);
`endif
        settle_low(12);
        check("final_level", int'(dut_if.sw_level), 0);
        check("final_busy",  int'(dut_if.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/switch_debounce_pulse.md
Name: switch_debounce_pulse

Overview:
- Front-end conditioning stage for the 4-bit ripple toggle counter.
- Takes a raw, bouncing board switch or button (the signal the counter currently uses directly as its clock).
- Synchronises and debounces it, then emits a clean debounced level and single-cycle edge pulses.
- `rise_pulse` drives the counter's first-stage clock/toggle input, so each press produces exactly one count.

Parameters:
- STABLE_COUNT, 1000000, cycles the synchronised input must hold a new value before acceptance (10 ms at 100 MHz); legal range >= 2.
- REPEAT_COUNT, 25000000, auto-repeat interval in cycles; used only when AUTO_REPEAT_EN is defined; legal range >= 2.
- Internal counter width is derived as $clog2 of the larger of the two parameters; no width parameter.

Ports:
- clk  input  1  system clock; all flops on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- sw_in  input  1  raw asynchronous switch/button level.
- sw_level  output  1  debounced level, registered.
- rise_pulse  output  1  one-cycle high on each accepted 0->1 transition (plus repeats, see Optional Feature).
- fall_pulse  output  1  one-cycle high on each accepted 1->0 transition.
- busy  output  1  high while a candidate transition is being qualified (WAIT_HIGH or WAIT_LOW).

Behaviour:
- Reset (rst=0, async):
  - sync flops s1, s2 = 0; state = IDLE_LOW; counter = 0.
  - sw_level = 0, rise_pulse = 0, fall_pulse = 0, busy = 0.
  - Takes effect immediately, regardless of state (mid-qualification, mid-pulse).
- Release: if sw_in is high at reset release, normal qualification runs and one rise_pulse is produced.
- Synchroniser: two flops, s1 <= sw_in, s2 <= s1. The FSM sees only s2.
- States: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - s2=1 -> WAIT_HIGH, counter <= 0.
  - Otherwise stay.
- WAIT_HIGH:
  - s2=0 -> IDLE_LOW, counter <= 0 (bounce rejected, no pulse).
  - s2=1 and counter == STABLE_COUNT-1 -> IDLE_HIGH; sw_level <= 1; rise_pulse <= 1.
  - Otherwise counter <= counter+1.
- IDLE_HIGH and WAIT_LOW: mirror of the above with polarity inverted. Acceptance sets sw_level <= 0 and fall_pulse <= 1.
- Pulses:
  - Registered, high for exactly one cycle, then cleared.
  - rise_pulse and fall_pulse are never high in the same cycle.
- busy = 1 exactly in WAIT_HIGH and WAIT_LOW; registered with the state.
- Latency: sw_in sampled high at edge E0 and held -> sw_level and rise_pulse go high after edge E0+STABLE_COUNT+2. The fall path is symmetric.
- Minimum pulse spacing: successive accepted transitions are at least STABLE_COUNT+1 cycles apart.
- Any glitch shorter than STABLE_COUNT cycles (after sync) produces no output change.
- Counter never exceeds STABLE_COUNT-1 (no wrap); it is cleared on every state entry.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - In IDLE_HIGH, a repeat counter increments each cycle while s2=1.
  - On reaching REPEAT_COUNT-1, rise_pulse is asserted for one cycle and the repeat counter clears; this repeats every REPEAT_COUNT cycles while held.
  - The repeat counter clears on entry to IDLE_HIGH and on reset.
  - sw_level is unaffected.
  - Used for holding the button to ripple the counter continuously.
- Undefined:
  - Exactly one rise_pulse per accepted press.
  - No repeat counter logic is synthesised.

Test Plan (STABLE_COUNT=4, REPEAT_COUNT=8 for simulation):
- Clean press: rst released, sw_in 0->1 at E0 and held -> sw_level=1 and rise_pulse=1 after E6; rise_pulse=0 after E7; busy high after E2..E5; fall_pulse stays 0.
- Bounce reject: sw_in high for 3 cycles, low 2, high 2, low, repeated for 40 cycles, then held low -> sw_level stays 0; no pulses; busy toggles.
- Press then release: hold high 20 cycles then low -> exactly one rise_pulse, then one fall_pulse 6 cycles after the falling sample; sw_level returns to 0.
- Reset mid-qualification: drive rst=0 while in WAIT_HIGH with counter=2 -> all outputs 0 immediately; after release with sw_in still high -> one rise_pulse 6 cycles after the first sampling edge.
- Downstream integration: 5 clean presses feeding the ripple counter with t=1 -> its register steps through the down-count sequence exactly 5 times, no extra edges.
- AUTO_REPEAT_EN defined, hold sw_in high 40 cycles after acceptance -> rise_pulse at acceptance, then every 8 cycles (5 pulses total); undefined -> 1 pulse.
